// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions for the skid stage.
// Holds the occupancy state encoding and the stage mode selectors.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int MODE_REG  = 0;
  localparam int MODE_SKID = 1;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear.
// Clear wins over load.
module pipe_data_reg #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture payload on load, zero on clear.
  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (ld)
      q <= d;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage: single register or two-entry skid buffer.
// out_data is always the main entry; the skid entry refills main on drain.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int WIDTH      = 96,
  parameter int MODE       = MODE_SKID,
  parameter int CLEAR_DATA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_e state, state_n;

  logic             in_fire;
  logic             out_fire;
  logic             main_ld;
  logic             main_from_skid;
  logic             skid_ld;
  logic             data_clr;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State register; reset and flush both empty the stage.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_EMPTY;
    else
      state <= state_n;
  end

  // Next-state and data-path load selection.
  always_comb begin
    state_n        = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_n = ST_BUSY;
          main_ld = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire && MODE == MODE_SKID) begin
          state_n = ST_FULL;
          skid_ld = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_n        = ST_BUSY;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    if (rst || flush) begin
      state_n = ST_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  // Registered ready breaks the out_ready -> in_ready path in skid mode.
  generate
    if (MODE == MODE_SKID) begin : g_skid_rdy
      logic rdy_q;
      // Ready is high whenever the next state still has a free entry.
      always_ff @(posedge clk) begin
        if (rst)
          rdy_q <= 1'b1;
        else
          rdy_q <= (state_n != ST_FULL);
      end
      assign in_ready = rdy_q;
    end else begin : g_comb_rdy
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  assign data_clr = (CLEAR_DATA != 0) && (rst || flush);
  assign main_d   = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .clr (data_clr),
    .ld  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .clr (data_clr),
    .ld  (skid_ld),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule
